// File: rtl/pixel_stream_system.sv
// Input FIFO -> two-stage pixel core (pass / gray / invert / threshold) -> output FIFO, one clock.
// Optional statistics outputs (stall_cycles, frame_count) are built when PIXEL_STREAM_STATS_EN is defined.

module pixel_stream_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  // A read at the same edge frees the head slot, so a write into a full FIFO still lands.
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module pixel_stream_system #(
  parameter int CHANNELS         = 3,
  parameter int CH_WIDTH         = 8,
  parameter int FIFO_BUFFER_SIZE = 16,
  parameter int FRAME_PIXELS     = 1024,
  parameter int THRESHOLD        = 128
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         fifo_in_wr_en,
  input  logic [CHANNELS*CH_WIDTH-1:0] fifo_in_din,
  output logic                         fifo_in_full,
  input  logic                         fifo_out_rd_en,
  output logic [CHANNELS*CH_WIDTH-1:0] fifo_out_dout,
  output logic                         fifo_out_empty,
  output logic                         frame_done,
  output logic [1:0]                   active_mode
`ifdef PIXEL_STREAM_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [15:0]                  frame_count
`endif
);
  localparam int PW = CHANNELS * CH_WIDTH;
  localparam int SW = CH_WIDTH + 2;
  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CW-1:0]       LAST     = CW'(FRAME_PIXELS - 1);
  localparam logic [CH_WIDTH-1:0] THRESH_L = CH_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_INVERT = 2'd2,
    MODE_THRESH = 2'd3
  } mode_t;

  logic [PW-1:0]       in_dout;
  logic                in_empty;
  logic                in_rd;
  logic                out_full;
  logic                out_wr;
  logic                adv;

  logic                s1_valid;
  logic [PW-1:0]       s1_pix;
  mode_t               s1_mode;
  logic                s2_valid;
  logic [PW-1:0]       s2_pix;

  logic [CW-1:0]       in_count;
  logic [CW-1:0]       out_count;
  mode_t               active_mode_q;
  mode_t               pix_mode;

  logic [SW-1:0]       sum;
  logic [CH_WIDTH-1:0] gray;
  logic [PW-1:0]       result;

  pixel_stream_fifo #(.WIDTH(PW), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_in (
    .clock (clock),
    .reset (reset),
    .wr_en (fifo_in_wr_en),
    .din   (fifo_in_din),
    .rd_en (in_rd),
    .dout  (in_dout),
    .full  (fifo_in_full),
    .empty (in_empty)
  );

  pixel_stream_fifo #(.WIDTH(PW), .DEPTH(FIFO_BUFFER_SIZE)) u_fifo_out (
    .clock (clock),
    .reset (reset),
    .wr_en (out_wr),
    .din   (s2_pix),
    .rd_en (fifo_out_rd_en),
    .dout  (fifo_out_dout),
    .full  (out_full),
    .empty (fifo_out_empty)
  );

  assign adv         = !s2_valid || !out_full;
  assign in_rd       = !in_empty && adv;
  assign out_wr      = s2_valid && !out_full;
  assign active_mode = active_mode_q;
  // The first pixel of a frame takes the live mode; the rest of the frame reuses the latched one.
  assign pix_mode    = (in_count == '0) ? mode_t'(mode) : active_mode_q;

  always_comb begin
    sum    = '0;
    result = s1_pix;
    for (int c = 0; c < CHANNELS; c++) begin
      sum = sum + SW'(s1_pix[c*CH_WIDTH +: CH_WIDTH]);
    end
    gray = CH_WIDTH'(sum / SW'(CHANNELS));
    case (s1_mode)
      MODE_PASS:   result = s1_pix;
      MODE_GRAY: begin
        for (int c = 0; c < CHANNELS; c++) result[c*CH_WIDTH +: CH_WIDTH] = gray;
      end
      MODE_INVERT: result = ~s1_pix;
      MODE_THRESH: begin
        for (int c = 0; c < CHANNELS; c++) result[c*CH_WIDTH +: CH_WIDTH] = {CH_WIDTH{gray >= THRESH_L}};
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_mode  <= MODE_PASS;
      s2_valid <= 1'b0;
      s2_pix   <= '0;
    end else if (adv) begin
      s1_valid <= in_rd;
      s1_pix   <= in_dout;
      s1_mode  <= pix_mode;
      s2_valid <= s1_valid;
      s2_pix   <= result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_count      <= '0;
      out_count     <= '0;
      active_mode_q <= MODE_PASS;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= out_wr && (out_count == LAST);
      if (in_rd) begin
        in_count <= (in_count == LAST) ? '0 : in_count + 1'b1;
        if (in_count == '0) active_mode_q <= mode_t'(mode);
      end
      if (out_wr) begin
        out_count <= (out_count == LAST) ? '0 : out_count + 1'b1;
      end
    end
  end

`ifdef PIXEL_STREAM_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      frame_count  <= '0;
    end else begin
      if (s2_valid && out_full && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pixel_stream_system.sv
// Self-checking bench for pixel_stream_system: table-driven frame vectors plus hand-written
// backpressure, mode-switch and mid-frame reset sequences, all checked through a scoreboard queue.

module tb_pixel_stream_system;
  localparam int CH = 3;
  localparam int CW = 8;
  localparam int PW = CH * CW;
  localparam int FP = 4;

  logic          clock;
  logic          reset;
  logic [1:0]    mode;
  logic          fifo_in_wr_en;
  logic [PW-1:0] fifo_in_din;
  logic          fifo_in_full;
  logic          fifo_out_rd_en;
  logic [PW-1:0] fifo_out_dout;
  logic          fifo_out_empty;
  logic          frame_done;
  logic [1:0]    active_mode;
`ifdef PIXEL_STREAM_STATS_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   frame_count;
`endif

  int            n_checks = 0;
  int            n_fail = 0;
  logic [PW-1:0] exp_q[$];
  bit            reader_on = 0;
  int            fd_pulses = 0;
  int            fd_long = 0;
  bit            fd_prev = 0;
  int            mdl_count = 0;
  logic [1:0]    mdl_mode = 2'd0;

  typedef struct {
    logic [1:0]    m;
    logic [PW-1:0] din;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t vecs[12];

  pixel_stream_system #(
    .CHANNELS(CH), .CH_WIDTH(CW), .FIFO_BUFFER_SIZE(16), .FRAME_PIXELS(FP), .THRESHOLD(128)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .fifo_in_wr_en  (fifo_in_wr_en),
    .fifo_in_din    (fifo_in_din),
    .fifo_in_full   (fifo_in_full),
    .fifo_out_rd_en (fifo_out_rd_en),
    .fifo_out_dout  (fifo_out_dout),
    .fifo_out_empty (fifo_out_empty),
    .frame_done     (frame_done),
    .active_mode    (active_mode)
`ifdef PIXEL_STREAM_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .frame_count    (frame_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] modelPixel(input logic [1:0] m, input logic [PW-1:0] p);
    int            s;
    logic [CW-1:0] g;
    logic [PW-1:0] r;
    s = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]);
    g = CW'(s / 3);
    case (m)
      2'd0:    r = p;
      2'd1:    r = {g, g, g};
      2'd2:    r = ~p;
      default: r = (g >= 8'd128) ? 24'hFFFFFF : 24'h000000;
    endcase
    return r;
  endfunction

  // Called at a negedge; writes one pixel and pushes its expected output.
  task automatic applyStimulus(input logic [1:0] m, input logic [PW-1:0] pix,
                               input bit use_exp, input logic [PW-1:0] exp_pix);
    int guard = 0;
    while (fifo_in_full && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (fifo_in_full) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL write_timeout: fifo_in_full still 1, required 0");
      return;
    end
    mode          = m;
    fifo_in_din   = pix;
    fifo_in_wr_en = 1'b1;
    if (mdl_count == 0) mdl_mode = m;
    exp_q.push_back(use_exp ? exp_pix : modelPixel(mdl_mode, pix));
    mdl_count = (mdl_count + 1) % FP;
    @(negedge clock);
    fifo_in_wr_en = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    mdl_count = 0;
  endtask

  // Reader: pops and compares the FIFO head, then strobes rd_en for the next edge.
  initial begin
    logic [PW-1:0] e;
    fifo_out_rd_en = 1'b0;
    forever begin
      @(negedge clock);
      fifo_out_rd_en = 1'b0;
      if (reader_on && !reset && !fifo_out_empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, required nothing", fifo_out_dout);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pixel", fifo_out_dout, e);
        end
        fifo_out_rd_en = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && frame_done) begin
        fd_pulses++;
        if (fd_prev) fd_long++;
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    int base;
    int lat;
    int a;
    int b;
    vecs[0]  = '{2'd1, 24'h1E140A, 24'h141414};
    vecs[1]  = '{2'd2, 24'h00FF80, 24'hFF007F};
    vecs[2]  = '{2'd3, 24'h808080, 24'hFFFFFF};
    vecs[3]  = '{2'd3, 24'h7F7F7F, 24'h000000};
    vecs[4]  = '{2'd0, 24'h123456, 24'h123456};
    vecs[5]  = '{2'd1, 24'hFFFFFF, 24'hFFFFFF};
    vecs[6]  = '{2'd1, 24'h000102, 24'h010101};
    vecs[7]  = '{2'd1, 24'h0000FF, 24'h555555};
    vecs[8]  = '{2'd3, 24'h80807F, 24'h000000};
    vecs[9]  = '{2'd2, 24'h000000, 24'hFFFFFF};
    vecs[10] = '{2'd3, 24'h818180, 24'hFFFFFF};
    vecs[11] = '{2'd1, 24'h030000, 24'h010101};

    reset = 1'b1;
    mode = 2'd0;
    fifo_in_wr_en = 1'b0;
    fifo_in_din = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_in_full", fifo_in_full, 0);
    checkOutput("rst_out_empty", fifo_out_empty, 1);
    checkOutput("rst_out_dout", fifo_out_dout, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_active_mode", active_mode, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] table vectors, one frame each");
    reader_on = 1;
    base = fd_pulses;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].m, vecs[i].din, 1, vecs[i].exp);
      lat = 0;
      while (fifo_out_empty && lat < 8) begin
        @(negedge clock);
        lat++;
      end
      checkOutput("first_latency", lat, 3);
      for (int k = 1; k < FP; k++) applyStimulus(vecs[i].m, vecs[i].din, 1, vecs[i].exp);
      waitDrain();
      checkOutput("vec_active_mode", active_mode, {30'd0, vecs[i].m});
    end
    checkOutput("table_frame_done", fd_pulses - base, 12);

    $display("[TB] mode switch mid-frame");
    base = fd_pulses;
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i < 2) ? 2'd1 : 2'd2, {8'(i * 7), 8'(i * 13 + 5), 8'(200 - i * 9)}, 0, '0);
    end
    waitDrain();
    checkOutput("switch_frame_done", fd_pulses - base, 2);
    checkOutput("switch_active_mode", active_mode, 2);

    $display("[TB] backpressure with reader stopped");
    reader_on = 0;
    for (int i = 0; i < 33; i++) applyStimulus(2'd0, {3{8'(i)}}, 0, '0);
    repeat (3) @(negedge clock);
    checkOutput("bp_not_full_33", fifo_in_full, 0);
    applyStimulus(2'd0, {3{8'(33)}}, 0, '0);
    repeat (3) @(negedge clock);
    checkOutput("bp_full_34", fifo_in_full, 1);
    checkOutput("bp_out_nonempty", fifo_out_empty, 0);
    checkOutput("bp_head", fifo_out_dout, 24'h000000);
    reader_on = 1;
    for (int i = 34; i < 40; i++) applyStimulus(2'd0, {3{8'(i)}}, 0, '0);
    waitDrain();
    checkOutput("bp_active_mode", active_mode, 0);

    $display("[TB] reset mid-frame");
    reader_on = 0;
    for (int i = 0; i < 5; i++) applyStimulus(2'd3, {3{8'(100 + i * 10)}}, 0, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_out_empty", fifo_out_empty, 1);
    checkOutput("mid_rst_active_mode", active_mode, 0);
    checkOutput("mid_rst_in_full", fifo_in_full, 0);
    checkOutput("mid_rst_dout", fifo_out_dout, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    mdl_count = 0;
    @(negedge clock);
    base = fd_pulses;
    reader_on = 1;
    for (int i = 0; i < 7; i++) applyStimulus(2'd2, {8'(i), 8'(i * 3), 8'(i * 5)}, 0, '0);
    waitDrain();
    checkOutput("post_rst_frame_done", fd_pulses - base, 1);
    checkOutput("post_rst_active_mode", active_mode, 2);

`ifdef PIXEL_STREAM_STATS_EN
    $display("[TB] statistics counters");
    reader_on = 0;
    doReset();
    @(negedge clock);
    checkOutput("stats_rst_stall", stall_cycles, 0);
    checkOutput("stats_rst_frames", frame_count, 0);
    for (int i = 0; i < 17; i++) applyStimulus(2'd0, {3{8'(i + 50)}}, 0, '0);
    repeat (5) @(negedge clock);
    a = int'(stall_cycles);
    repeat (10) @(negedge clock);
    b = int'(stall_cycles);
    checkOutput("stats_stall_delta", b - a, 10);
    reader_on = 1;
    waitDrain();
    checkOutput("stats_frames", frame_count, 4);
`else
    a = 0;
    b = 0;
`endif

    checkOutput("frame_done_width", fd_long, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
